// File: rtl/booth_mul_acc.sv
// Sequential 64x64 signed radix-4 Booth multiplier: control FSM plus 128-bit accumulator.
// Drives an external combinational booth_enc with num/mpr_ext and consumes one digit per clock.
module booth_mul_acc (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         op_start,
  input  logic         op_clear,
  input  logic [63:0]  multiplicand,
  input  logic [63:0]  multiplier,
  output logic [7:0]   num,
  output logic [64:0]  mpr_ext,
  input  logic [2:0]   B_operation,
  input  logic         s_interrupt,
  input  logic [7:0]   next_num,
  output logic [127:0] result,
  output logic         op_done
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     num_q, num_d;
  logic [64:0]    mpr_q, mpr_d;
  logic [63:0]    m_q, m_d;
  logic [127:0]   acc_q, acc_d;
  logic [127:0]   result_q, result_d;
  logic           op_done_q, op_done_d;

  logic [127:0]   m_ext;
  logic [127:0]   sel;
  logic [127:0]   pp;
  logic [7:0]     shamt;

  // Digit centred on bit num carries weight 2^(num-1).
  always_comb begin
    m_ext = {{64{m_q[63]}}, m_q};
    shamt = num_q - 8'd1;
    case (B_operation)
      3'b001:  sel = m_ext;
      3'b011:  sel = m_ext << 1;
      3'b010:  sel = -m_ext;
      3'b100:  sel = -(m_ext << 1);
      default: sel = '0;
    endcase
    pp = sel << shamt;
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    mpr_d     = mpr_q;
    m_d       = m_q;
    acc_d     = acc_q;
    result_d  = result_q;
    op_done_d = 1'b0;

    if (op_clear) begin
      state_d  = StIdle;
      acc_d    = '0;
      result_d = '0;
      num_d    = 8'h01;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (op_start) begin
            m_d     = multiplicand;
            mpr_d   = {multiplier, 1'b0};
            acc_d   = '0;
            num_d   = 8'h01;
            state_d = StExec;
          end else if (state_q == StDone) begin
            // Done flag and result register lag the state by one cycle.
            op_done_d = 1'b1;
            result_d  = acc_q;
          end
        end
        StExec: begin
          acc_d = acc_q + pp;
          num_d = next_num;
          if (s_interrupt) begin
            state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      num_q     <= 8'h01;
      mpr_q     <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      op_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      mpr_q     <= mpr_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      op_done_q <= op_done_d;
    end
  end

  assign num     = num_q;
  assign mpr_ext = mpr_q;
  assign result  = result_q;
  assign op_done = op_done_q;

endmodule

// File: tb/tb_booth_mul_acc.sv
// Self-checking bench for booth_mul_acc with a behavioural booth_enc and a result scoreboard.
module tb_booth_mul_acc;

  logic         clk;
  logic         reset_n;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic [7:0]   num;
  logic [64:0]  mpr_ext;
  logic [2:0]   B_operation;
  logic         s_interrupt;
  logic [7:0]   next_num;
  logic [127:0] result;
  logic         op_done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] sb[$];

  booth_mul_acc dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .num          (num),
    .mpr_ext      (mpr_ext),
    .B_operation  (B_operation),
    .s_interrupt  (s_interrupt),
    .next_num     (next_num),
    .result       (result),
    .op_done      (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural booth_enc: radix-4 recoding of mpr_ext[num+1:num-1].
  always_comb begin
    int idx;
    logic [2:0] trip;
    idx  = int'(num);
    trip = 3'b000;
    if (idx >= 1 && idx <= 63) trip = {mpr_ext[idx+1], mpr_ext[idx], mpr_ext[idx-1]};
    case (trip)
      3'b001, 3'b010: B_operation = 3'b001;
      3'b011:         B_operation = 3'b011;
      3'b100:         B_operation = 3'b100;
      3'b101, 3'b110: B_operation = 3'b010;
      default:        B_operation = 3'b000;
    endcase
    s_interrupt = (num == 8'h3F);
    next_num    = num + 8'd2;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [127:0] prod(input logic [63:0] m, input logic [63:0] q);
    logic signed [127:0] a, b;
    a = $signed({{64{m[63]}}, m});
    b = $signed({{64{q[63]}}, q});
    return a * b;
  endfunction

  // Pulses op_start for one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [63:0] m, input logic [63:0] q, input logic [127:0] exp);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    op_start     = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    op_start     = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
  endtask

  task automatic wait_done(input string tag, input int elapsed);
    int cyc;
    logic [127:0] exp;
    cyc = elapsed;
    while (!op_done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 128'(cyc), 128'd33);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    check_eq({tag, "_result"}, result, exp);
  endtask

  task automatic run_op(input string tag, input logic [63:0] m, input logic [63:0] q,
                        input logic [127:0] exp);
    start_op(m, q, exp);
    wait_done(tag, 0);
  endtask

  initial begin
    logic [63:0] rm, rq;
    reset_n      = 1'b0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #12;
    check_eq("rst_done", 128'(op_done), 128'd0);
    check_eq("rst_result", result, 128'd0);
    check_eq("rst_num", 128'(num), 128'h01);
    check_eq("rst_mpr", 128'(mpr_ext), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("t1_3x5", 64'd3, 64'd5, 128'd15);
    run_op("t2_m1xm1", '1, '1, 128'd1);
    run_op("t2_zero", 64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0);
    run_op("t3_maxmin", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
           128'hC0000000_00000000_80000000_00000000);

    // Restart request mid-EXEC must be ignored.
    start_op(64'd1000, -64'sd3, -128'sd3000);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    multiplicand = 64'd77;
    multiplier   = 64'd11;
    op_start     = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    wait_done("t4_ignore", 10);

    // Clear at EXEC cycle 17 overrides a simultaneous start.
    start_op(64'd123, 64'd456, 128'd56088);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    op_clear     = 1'b1;
    op_start     = 1'b1;
    multiplicand = 64'd5;
    multiplier   = 64'd5;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    op_start = 1'b0;
    sb.delete();
    check_eq("t5_clr_done", 128'(op_done), 128'd0);
    check_eq("t5_clr_result", result, 128'd0);
    check_eq("t5_clr_num", 128'(num), 128'h01);
    repeat (40) @(posedge clk);
    #1;
    check_eq("t5_stay_idle", 128'(op_done), 128'd0);
    run_op("t5_m7x9", -64'sd7, 64'd9, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFC1);

    // Asynchronous reset mid-EXEC.
    start_op(64'd9, 64'd9, 128'd81);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check_eq("t6_rst_done", 128'(op_done), 128'd0);
    check_eq("t6_rst_result", result, 128'd0);
    check_eq("t6_rst_num", 128'(num), 128'h01);
    check_eq("t6_rst_mpr", 128'(mpr_ext), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("t6_no_resume", 128'(op_done), 128'd0);

    for (int i = 0; i < 1000; i++) begin
      rm = {$urandom, $urandom};
      rq = {$urandom, $urandom};
      case (i % 10)
        0: rm = 64'h8000_0000_0000_0000;
        1: rq = 64'h8000_0000_0000_0000;
        2: rm = '1;
        3: rq = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      run_op("rand", rm, rq, prod(rm, rq));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
